sram_arb_ctrl: RTL and testbench

Two-port arbiter and cycle sequencer for the external 16-bit asynchronous SRAM. It accepts word read/write requests from two on-chip requesters and grants them round-robin. Each granted access becomes a glitch-free SETUP/ACCESS/DONE strobe sequence on the SRAM pins. It owns the bidirectional data bus and sits between the user logic and the SRAM pads.

---
 rtl/sram_arb_ctrl.sv | 144 ++++++++++++++
 tb/tb_sram_arb_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter and SETUP/ACCESS/DONE strobe sequencer for a 16-bit asynchronous SRAM.
// Define SRAM_FIXED_PRIO_EN for fixed priority (port 0 wins ties) instead of round-robin.
module sram_arb_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [15:0]       p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_ack,
  output logic [15:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [15:0]       p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_ack,
  output logic [15:0]       p1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state;
  logic              gnt;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic              dq_oe;
  logic [3:0]        wait_cnt;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic [1:0]        sel_be;
`ifndef SRAM_FIXED_PRIO_EN
  logic              last_grant;
`endif

  always_comb begin
    pick = 1'b0;
`ifdef SRAM_FIXED_PRIO_EN
    pick = ~p0_req;
`else
    if (p0_req && p1_req) pick = ~last_grant;
    else                  pick = ~p0_req;
`endif
  end

  assign sel_we    = pick ? p1_we    : p0_we;
  assign sel_addr  = pick ? p1_addr  : p0_addr;
  assign sel_wdata = pick ? p1_wdata : p0_wdata;
  assign sel_be    = pick ? p1_be    : p0_be;

  assign sram_dq = dq_oe ? wdata_q : 16'bz;
  assign busy    = (state != IDLE);

  // Strobes are registered on entry to each state, so the pins always reflect the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      dq_oe      <= 1'b0;
      wait_cnt   <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
`ifndef SRAM_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            gnt        <= pick;
`ifndef SRAM_FIXED_PRIO_EN
            last_grant <= pick;
`endif
            we_q       <= sel_we;
            wdata_q    <= sel_wdata;
            sram_addr  <= sel_addr;
            sram_ce_n  <= 1'b0;
            sram_ub_n  <= ~sel_be[1];
            sram_lb_n  <= ~sel_be[0];
            sram_oe_n  <= sel_we;
            sram_we_n  <= 1'b1;
            dq_oe      <= sel_we;
            state      <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt  <= 4'(WAIT_CYCLES);
          sram_we_n <= ~we_q;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (wait_cnt == 4'd1) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!we_q) begin
              if (gnt) p1_rdata <= sram_dq;
              else     p0_rdata <= sram_dq;
            end
            if (gnt) p1_ack <= 1'b1;
            else     p0_ack <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          dq_oe     <= 1'b0;
          sram_ub_n <= 1'b1;
          sram_lb_n <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl with a small SRAM model; idle bus is probed with a known pattern
// so that any controller drive outside write cycles corrupts the observed value.
`timescale 1ns/1ps
module tb_sram_arb_ctrl;
  localparam int unsigned AW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [15:0]   p0_wdata, p1_wdata;
  logic [1:0]    p0_be, p1_be;
  logic          p0_ack, p1_ack;
  logic [15:0]   p0_rdata, p1_rdata;
  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_dq;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy;

  logic          s_req, s_ack, s1_ack, s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n, s_busy;
  logic [15:0]   s_rdata, s1_rdata;
  logic [AW-1:0] s_addr;
  wire  [15:0]   s_dq;

  sram_arb_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy)
  );

  sram_arb_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_dut_ws (
    .clk(clk), .rst_n(rst_n),
    .p0_req(s_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_ack(s_ack), .p0_rdata(s_rdata),
    .p1_req(1'b0), .p1_we(1'b0), .p1_addr('0), .p1_wdata(16'h0000), .p1_be(2'b00),
    .p1_ack(s1_ack), .p1_rdata(s1_rdata),
    .sram_addr(s_addr), .sram_dq(s_dq), .sram_ce_n(s_ce_n), .sram_oe_n(s_oe_n),
    .sram_we_n(s_we_n), .sram_ub_n(s_ub_n), .sram_lb_n(s_lb_n), .busy(s_busy)
  );

  logic [15:0] mem [0:255];
  logic        probe;
  logic        rd_en;
  assign rd_en   = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq = rd_en ? mem[sram_addr[7:0]] : (probe ? 16'h5A5A : 16'bz);

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_rd0, exp_rd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
    end else begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
    end
  endtask

  // One isolated access on the WAIT_CYCLES=1 instance, checked phase by phase.
  task automatic run_access(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [15:0] d, input logic [1:0] be, input logic [15:0] exp_rd);
    logic [15:0] bus_exp;
    logic [1:0]  nbe;
    nbe     = ~be;
    bus_exp = we ? d : exp_rd;
    probe   = !we;
    drive(p, 1'b1, we, a, d, be);
    tick();
    check("setup_ce", sram_ce_n, 0);
    check("setup_oe", sram_oe_n, we);
    check("setup_we", sram_we_n, 1);
    check("setup_bytes", {sram_ub_n, sram_lb_n}, nbe);
    check("setup_addr", sram_addr, a);
    check("setup_dq", sram_dq, bus_exp);
    check("setup_busy", busy, 1);
    drive(p, 1'b1, !we, ~a, ~d, ~be);
    tick();
    check("access_we", sram_we_n, !we);
    check("access_oe", sram_oe_n, we);
    check("access_bytes", {sram_ub_n, sram_lb_n}, nbe);
    check("access_addr", sram_addr, a);
    check("access_dq", sram_dq, bus_exp);
    check("access_acks", {p0_ack, p1_ack}, 0);
    tick();
    if (!we) begin
      if (p == 0) exp_rd0 = exp_rd;
      else        exp_rd1 = exp_rd;
    end
    check("done_ack", (p == 0) ? p0_ack : p1_ack, 1);
    check("done_other_ack", (p == 0) ? p1_ack : p0_ack, 0);
    check("done_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("done_addr", sram_addr, a);
    check("done_dq", sram_dq, we ? d : 16'h5A5A);
    check("p0_rdata", p0_rdata, exp_rd0);
    check("p1_rdata", p1_rdata, exp_rd1);
    drive(p, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    probe = 1'b1;
    tick();
    check("idle_acks", {p0_ack, p1_ack}, 0);
    check("idle_busy", busy, 0);
    check("idle_dq", sram_dq, 16'h5A5A);
    check("idle_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
  endtask

  int unsigned gap, lat, we_low, cyc, last_cyc, n_acks;
  logic        prev0, prev1;
  int          order [4];
  int          exp_order [4];

  initial begin
    rst_n = 1'b0; probe = 1'b1; s_req = 1'b0;
    exp_rd0 = '0; exp_rd1 = '0;
    drive(0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    #12;
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
    check("rst_addr", sram_addr, 0);
    check("rst_dq", sram_dq, 16'h5A5A);
    check("rst_acks", {p0_ack, p1_ack}, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_access(0, 1'b1, 18'h00010, 16'hA5C3, 2'b11, 16'h0000);
    run_access(0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'hA5C3);
    run_access(1, 1'b1, 18'h00040, 16'h1234, 2'b01, 16'h0000);
    run_access(1, 1'b1, 18'h00040, 16'hABFF, 2'b10, 16'h0000);
    run_access(1, 1'b1, 18'h00040, 16'hFFFF, 2'b00, 16'h0000);
    run_access(0, 1'b0, 18'h00040, 16'h0000, 2'b11, 16'hAB34);
    run_access(1, 1'b0, 18'h00040, 16'h0000, 2'b00, 16'hAB34);

    // p1 raises its request while p0 is in ACCESS and must wait for IDLE.
    probe = 1'b0;
    drive(0, 1'b1, 1'b1, 18'h00050, 16'h7777, 2'b11);
    tick();
    tick();
    drive(1, 1'b1, 1'b0, 18'h00050, 16'h0000, 2'b11);
    tick();
    check("late_p0_ack", p0_ack, 1);
    check("late_p1_waits", p1_ack, 0);
    drive(0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    probe = 1'b1;
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!p1_ack && gap < 20);
    check("late_gap", gap, 4);
    check("late_rdata", p1_rdata, 16'h7777);
    exp_rd1 = 16'h7777;
    drive(1, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    tick();

    drive(0, 1'b0, 1'b1, 18'h00003, 16'h0F0F, 2'b11);
    s_req  = 1'b1;
    lat    = 0;
    we_low = 0;
    do begin
      tick();
      lat++;
      if (!s_we_n) we_low++;
    end while (!s_ack && lat < 30);
    check("ws_latency", lat, 5);
    check("ws_we_low", we_low, 3);
    s_req = 1'b0;
    tick();
    check("ws_ack_pulse", s_ack, 0);

    probe = 1'b0;
    drive(0, 1'b1, 1'b1, 18'h00060, 16'hA5A5, 2'b11);
    tick();
    tick();
    check("pre_rst_we", sram_we_n, 0);
    #2;
    rst_n = 1'b0;
    probe = 1'b1;
    #1;
    check("rst_mid_we_ce", {sram_we_n, sram_ce_n}, 2'b11);
    check("rst_mid_dq", sram_dq, 16'h5A5A);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ack", {p0_ack, p1_ack}, 0);
    drive(0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    exp_rd0 = '0;
    exp_rd1 = '0;
    @(negedge clk) rst_n = 1'b1;

    drive(0, 1'b1, 1'b0, 18'h00010, 16'h0000, 2'b11);
    drive(1, 1'b1, 1'b0, 18'h00040, 16'h0000, 2'b11);
    n_acks = 0; cyc = 0; last_cyc = 0; prev0 = 1'b0; prev1 = 1'b0;
    while (n_acks < 4 && cyc < 60) begin
      tick();
      cyc++;
      check("ack_overlap", p0_ack & p1_ack, 0);
      check("ack0_width", p0_ack & prev0, 0);
      check("ack1_width", p1_ack & prev1, 0);
      prev0 = p0_ack;
      prev1 = p1_ack;
      if (p0_ack || p1_ack) begin
        order[n_acks] = p1_ack ? 1 : 0;
        if (n_acks > 0) check("grant_spacing", cyc - last_cyc, 4);
        last_cyc = cyc;
        n_acks++;
      end
    end
    drive(0, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, '0, 16'h0000, 2'b00);
    check("grant_count", n_acks, 4);
`ifdef SRAM_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
    exp_rd1   = 16'h0000;
`else
    exp_order = '{0, 1, 0, 1};
    exp_rd1   = 16'hAB34;
`endif
    for (int i = 0; i < 4; i++) check("grant_order", order[i], exp_order[i]);
    check("contend_p0_rdata", p0_rdata, 16'hA5C3);
    check("contend_p1_rdata", p1_rdata, exp_rd1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
